qs_prog_encoder: RTL and testbench

QS_PROG_ENCODER -- requirements
Module: qs_prog_encoder

---
 rtl/qs_pkg.sv | 191 +++++++++++++++++++
 rtl/qs_prog_encoder.sv | 121 ++++++++++++
 tb/tb_qs_prog_encoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// rtl/qs_pkg.sv - instruction types, field positions, encode and decode helpers
package qs_pkg;

  typedef logic [2:0]  reg_t;
  typedef logic [2:0]  imm_t;
  typedef logic [7:0]  pc_t;
  typedef logic [15:0] inst_t;

  typedef enum logic [1:0] {
    CC_EQ = 2'd0,
    CC_NE = 2'd1,
    CC_GT = 2'd2,
    CC_LT = 2'd3
  } cc_t;

  typedef enum logic [4:0] {
    MN_NOP  = 5'd0,
    MN_J    = 5'd1,
    MN_PUSH = 5'd2,
    MN_POP  = 5'd3,
    MN_LD   = 5'd4,
    MN_ST   = 5'd5,
    MN_MOV  = 5'd6,
    MN_MOVI = 5'd7,
    MN_MOVS = 5'd8,
    MN_ADD  = 5'd9,
    MN_ADDI = 5'd10,
    MN_SUB  = 5'd11,
    MN_SUBI = 5'd12,
    MN_CALL = 5'd13,
    MN_RET  = 5'd14,
    MN_WAIT = 5'd15,
    MN_EMIT = 5'd16
  } mnemonic_t;

  localparam int OPC_LSB = 12;
  localparam int SEL_BIT = 11;
  localparam int R_LSB   = 8;
  localparam int W_BIT   = 7;
  localparam int S_LSB   = 4;
  localparam int IMM_BIT = 3;
  localparam int U_LSB   = 0;
  localparam int CC_LSB  = 8;
  localparam int A_LSB   = 0;

  localparam logic [3:0] OPC_NOP   = 4'b0000;
  localparam logic [3:0] OPC_J     = 4'b0001;
  localparam logic [3:0] OPC_STACK = 4'b0010;
  localparam logic [3:0] OPC_MEM   = 4'b0100;
  localparam logic [3:0] OPC_MOV   = 4'b0110;
  localparam logic [3:0] OPC_ARITH = 4'b0111;
  localparam logic [3:0] OPC_CALL  = 4'b1100;
  localparam logic [3:0] OPC_SYS   = 4'b1111;

  typedef struct packed {
    reg_t dst;
    reg_t src0;
    reg_t src1;
    imm_t imm;
    logic wren;
    cc_t  cc;
    pc_t  target;
  } fields_t;

  // Fields a given op does not use stay zero so decode output is canonical.
  typedef struct packed {
    mnemonic_t op;
    reg_t      dst;
    reg_t      src0;
    reg_t      src1;
    imm_t      imm;
    logic      wren;
    cc_t       cc;
    pc_t       target;
    logic      invalid_inst;
  } ucode_t;

  function automatic logic op_valid(logic [4:0] op);
    return op <= 5'd16;
  endfunction

  function automatic inst_t encode(mnemonic_t op, fields_t f);
    inst_t w;
    w = '0;
    case (op)
      MN_J: begin
        w[OPC_LSB +: 4] = OPC_J;
        w[CC_LSB +: 2]  = f.cc;
        w[A_LSB +: 8]   = f.target;
      end
      MN_PUSH: begin
        w[OPC_LSB +: 4] = OPC_STACK;
        w[U_LSB +: 3]   = f.src1;
      end
      MN_POP: begin
        w[OPC_LSB +: 4] = OPC_STACK;
        w[SEL_BIT]      = 1'b1;
        w[R_LSB +: 3]   = f.dst;
      end
      MN_LD: begin
        w[OPC_LSB +: 4] = OPC_MEM;
        w[R_LSB +: 3]   = f.dst;
        w[U_LSB +: 3]   = f.src1;
      end
      MN_ST: begin
        w[OPC_LSB +: 4] = OPC_MEM;
        w[SEL_BIT]      = 1'b1;
        w[S_LSB +: 3]   = f.src0;
        w[U_LSB +: 3]   = f.src1;
      end
      MN_MOV, MN_MOVI, MN_MOVS: begin
        w[OPC_LSB +: 4] = OPC_MOV;
        w[SEL_BIT]      = (op == MN_MOVS);
        w[IMM_BIT]      = (op == MN_MOVI);
        w[R_LSB +: 3]   = f.dst;
        w[U_LSB +: 3]   = (op == MN_MOV) ? f.src1 : f.imm;
      end
      MN_ADD, MN_ADDI, MN_SUB, MN_SUBI: begin
        w[OPC_LSB +: 4] = OPC_ARITH;
        w[SEL_BIT]      = (op == MN_SUB) || (op == MN_SUBI);
        w[R_LSB +: 3]   = f.dst;
        w[W_BIT]        = f.wren;
        w[S_LSB +: 3]   = f.src0;
        w[IMM_BIT]      = (op == MN_ADDI) || (op == MN_SUBI);
        w[U_LSB +: 3]   = w[IMM_BIT] ? f.imm : f.src1;
      end
      MN_CALL: begin
        w[OPC_LSB +: 4] = OPC_CALL;
        w[A_LSB +: 8]   = f.target;
      end
      MN_RET: begin
        w[OPC_LSB +: 4] = OPC_CALL;
        w[SEL_BIT]      = 1'b1;
      end
      MN_WAIT: w[OPC_LSB +: 4] = OPC_SYS;
      MN_EMIT: begin
        w[OPC_LSB +: 4] = OPC_SYS;
        w[SEL_BIT]      = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic ucode_t decode(inst_t w);
    ucode_t u;
    logic   sel;
    u   = '0;
    sel = w[SEL_BIT];
    case (w[OPC_LSB +: 4])
      OPC_NOP: u.op = MN_NOP;
      OPC_J: begin
        u.op     = MN_J;
        u.cc     = cc_t'(w[CC_LSB +: 2]);
        u.target = w[A_LSB +: 8];
      end
      OPC_STACK: begin
        u.op = sel ? MN_POP : MN_PUSH;
        if (sel) u.dst = w[R_LSB +: 3];
        else     u.src1 = w[U_LSB +: 3];
      end
      OPC_MEM: begin
        u.op   = sel ? MN_ST : MN_LD;
        u.src1 = w[U_LSB +: 3];
        if (sel) u.src0 = w[S_LSB +: 3];
        else     u.dst = w[R_LSB +: 3];
      end
      OPC_MOV: begin
        u.dst = w[R_LSB +: 3];
        if (sel)               begin u.op = MN_MOVS; u.imm = w[U_LSB +: 3]; end
        else if (w[IMM_BIT])   begin u.op = MN_MOVI; u.imm = w[U_LSB +: 3]; end
        else                   begin u.op = MN_MOV;  u.src1 = w[U_LSB +: 3]; end
      end
      OPC_ARITH: begin
        u.dst  = w[R_LSB +: 3];
        u.src0 = w[S_LSB +: 3];
        u.wren = w[W_BIT];
        if (w[IMM_BIT]) begin u.op = sel ? MN_SUBI : MN_ADDI; u.imm = w[U_LSB +: 3]; end
        else            begin u.op = sel ? MN_SUB : MN_ADD;   u.src1 = w[U_LSB +: 3]; end
      end
      OPC_CALL: begin
        u.op = sel ? MN_RET : MN_CALL;
        if (!sel) u.target = w[A_LSB +: 8];
      end
      OPC_SYS: u.op = sel ? MN_EMIT : MN_WAIT;
      default: u.invalid_inst = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/qs_prog_encoder.sv
// rtl/qs_prog_encoder.sv - streams instruction requests into encoded program-memory writes
module qs_prog_encoder
  import qs_pkg::*;
#(
  parameter logic [7:0] PC_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_dst,
  input  logic [2:0]  req_src0,
  input  logic [2:0]  req_src1,
  input  logic [2:0]  req_imm,
  input  logic        req_wren,
  input  logic [1:0]  req_cc,
  input  logic [7:0]  req_target,
  input  logic        req_last,
  output logic        prog_wr_en,
  output logic [7:0]  prog_wr_addr,
  output logic [15:0] prog_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  pc_t        addr_q, addr_d;
  logic [8:0] n_acc_q, n_acc_d;
  logic [8:0] count_q, count_d;
  logic       wr_en_q, wr_en_d;
  pc_t        wr_addr_q, wr_addr_d;
  inst_t      wr_data_q, wr_data_d;

  fields_t    fields;
  logic       op_ok;
  logic       full;

  assign fields = '{dst: req_dst, src0: req_src0, src1: req_src1, imm: req_imm,
                    wren: req_wren, cc: cc_t'(req_cc), target: req_target};
  assign op_ok  = op_valid(req_op);
  // Acceptances are counted separately from writes so the 257th request is
  // caught even while the 256th write is still in flight.
  assign full   = n_acc_q[8];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    n_acc_d   = n_acc_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_q) count_d = count_q + 9'd1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = PC_BASE;
          n_acc_d = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (req_vld) begin
          if (!op_ok || full) begin
            state_d = ST_ERR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = encode(mnemonic_t'(req_op), fields);
            addr_d    = addr_q + 8'd1;
            n_acc_d   = n_acc_q + 9'd1;
            if (req_last) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      n_acc_q   <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      n_acc_q   <= n_acc_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req_rdy      = (state_q == ST_LOAD);
  assign prog_wr_en   = wr_en_q;
  assign prog_wr_addr = wr_addr_q;
  assign prog_wr_data = wr_data_q;
  assign busy         = (state_q == ST_LOAD) || wr_en_q;
  assign done         = (state_q == ST_DONE) && !wr_en_q;
  assign error        = (state_q == ST_ERR);
  assign count        = count_q;

endmodule

// File: tb/tb_qs_prog_encoder.sv
// tb/tb_qs_prog_encoder.sv - scoreboard bench for qs_prog_encoder
module tb_qs_prog_encoder;
  import qs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        req_vld;
  logic        req_rdy;
  logic [4:0]  req_op;
  logic [2:0]  req_dst, req_src0, req_src1, req_imm;
  logic        req_wren;
  logic [1:0]  req_cc;
  logic [7:0]  req_target;
  logic        req_last;
  logic        prog_wr_en;
  logic [7:0]  prog_wr_addr;
  logic [15:0] prog_wr_data;
  logic        busy, done, error;
  logic [8:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    ucode_t      uc;
  } exp_t;
  exp_t sb[$];
  logic [7:0] exp_addr;

  qs_prog_encoder #(.PC_BASE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_op(req_op), .req_dst(req_dst), .req_src0(req_src0), .req_src1(req_src1),
    .req_imm(req_imm), .req_wren(req_wren), .req_cc(req_cc), .req_target(req_target),
    .req_last(req_last), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(logic [4:0] op, logic [2:0] d, logic [2:0] s0,
      logic [2:0] s1, logic [2:0] im, logic w, logic [1:0] cc, logic [7:0] t);
    case (op)
      MN_J:    return {4'b0001, 2'b00, cc, t};
      MN_PUSH: return {4'b0010, 1'b0, 8'h00, s1};
      MN_POP:  return {4'b0010, 1'b1, d, 8'h00};
      MN_LD:   return {4'b0100, 1'b0, d, 5'b0, s1};
      MN_ST:   return {4'b0100, 1'b1, 3'b0, 1'b0, s0, 1'b0, s1};
      MN_MOV:  return {4'b0110, 1'b0, d, 5'b0, s1};
      MN_MOVI: return {4'b0110, 1'b0, d, 4'b0, 1'b1, im};
      MN_MOVS: return {4'b0110, 1'b1, d, 5'b0, im};
      MN_ADD:  return {4'b0111, 1'b0, d, w, s0, 1'b0, s1};
      MN_ADDI: return {4'b0111, 1'b0, d, w, s0, 1'b1, im};
      MN_SUB:  return {4'b0111, 1'b1, d, w, s0, 1'b0, s1};
      MN_SUBI: return {4'b0111, 1'b1, d, w, s0, 1'b1, im};
      MN_CALL: return {4'b1100, 4'b0000, t};
      MN_RET:  return 16'hC800;
      MN_WAIT: return 16'hF000;
      MN_EMIT: return 16'hF800;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic ucode_t exp_uc(logic [4:0] op, logic [2:0] d, logic [2:0] s0,
      logic [2:0] s1, logic [2:0] im, logic w, logic [1:0] cc, logic [7:0] t);
    ucode_t u;
    u = '0;
    u.op = mnemonic_t'(op);
    case (op)
      MN_J:    begin u.cc = cc_t'(cc); u.target = t; end
      MN_PUSH: u.src1 = s1;
      MN_POP:  u.dst = d;
      MN_LD, MN_MOV: begin u.dst = d; u.src1 = s1; end
      MN_ST:   begin u.src0 = s0; u.src1 = s1; end
      MN_MOVI, MN_MOVS: begin u.dst = d; u.imm = im; end
      MN_ADD, MN_SUB:   begin u.dst = d; u.src0 = s0; u.src1 = s1; u.wren = w; end
      MN_ADDI, MN_SUBI: begin u.dst = d; u.src0 = s0; u.imm = im; u.wren = w; end
      MN_CALL: u.target = t;
      default: ;
    endcase
    return u;
  endfunction

  always @(negedge clk) begin
    if (prog_wr_en !== 1'b0) begin
      exp_t   e;
      ucode_t got;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%02h data=%04h, no write expected", prog_wr_addr, prog_wr_data);
      end else begin
        e = sb.pop_front();
        if (prog_wr_addr !== e.addr) begin
          failures++;
          $display("FAIL wr_addr: got %02h expected %02h", prog_wr_addr, e.addr);
        end
        checks++;
        if (prog_wr_data !== e.data) begin
          failures++;
          $display("FAIL wr_data @%02h: got %04h expected %04h", e.addr, prog_wr_data, e.data);
        end
        checks++;
        got = decode(prog_wr_data);
        if (got !== e.uc) begin
          failures++;
          $display("FAIL decode @%02h: got %h expected %h", e.addr, got, e.uc);
        end
      end
    end
  end

  task automatic idle_inputs();
    start = 0; req_vld = 0; req_op = '0; req_dst = '0; req_src0 = '0; req_src1 = '0;
    req_imm = '0; req_wren = 0; req_cc = '0; req_target = '0; req_last = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    exp_addr = 8'h00;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic send(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s0,
      input logic [2:0] s1, input logic [2:0] im, input logic w, input logic [1:0] cc,
      input logic [7:0] t, input logic last, input bit exp_wr);
    req_vld = 1; req_op = op; req_dst = d; req_src0 = s0; req_src1 = s1; req_imm = im;
    req_wren = w; req_cc = cc; req_target = t; req_last = last;
    if (exp_wr) begin
      sb.push_back('{addr: exp_addr, data: exp_word(op, d, s0, s1, im, w, cc, t),
                     uc: exp_uc(op, d, s0, s1, im, w, cc, t)});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk);
    @(negedge clk);
    req_vld = 0; req_last = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_rdy, prog_wr_en, prog_wr_addr, prog_wr_data, busy, done, error, count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b en=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%0d, all zero expected",
               req_rdy, prog_wr_en, prog_wr_addr, prog_wr_data, busy, done, error, count);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_addi();
    pulse_start();
    checks++;
    if (req_rdy !== 1'b1) begin failures++; $display("FAIL start_rdy: got %b expected 1", req_rdy); end
    send(MN_ADDI, 3'd2, 3'd1, 3'd0, 3'd3, 1'b1, 2'd0, 8'h00, 1'b1, 1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL addi_write_cycle: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 9'd1 || busy !== 1'b0 || req_rdy !== 1'b0) begin
      failures++; $display("FAIL addi_done: done=%b count=%0d busy=%b rdy=%b expected 1,1,0,0", done, count, busy, req_rdy);
    end
  endtask

  task automatic test_jump_ret();
    pulse_start();
    send(MN_J, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, CC_GT, 8'h42, 1'b0, 1);
    send(MN_RET, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 9'd2) begin
      failures++; $display("FAIL jret_done: done=%b count=%0d expected 1,2", done, count);
    end
  endtask

  task automatic test_not_ready();
    req_vld = 1; req_op = MN_NOP; req_last = 1;
    repeat (2) @(negedge clk);
    req_vld = 0; req_last = 0;
    checks++;
    if (count !== 9'd2 || done !== 1'b1) begin
      failures++; $display("FAIL not_ready: count=%0d done=%b expected 2,1", count, done);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    for (int i = 0; i < 256; i++)
      send(MN_MOVI, 3'(i), 3'd0, 3'd0, 3'(i >> 3), 1'b0, 2'd0, 8'h00, 1'b0, 1);
    @(negedge clk);
    checks++;
    if (count !== 9'd256 || error !== 1'b0 || req_rdy !== 1'b1) begin
      failures++; $display("FAIL b2b_256: count=%0d error=%b rdy=%b expected 256,0,1", count, error, req_rdy);
    end
    send(MN_MOVI, 3'd1, 3'd0, 3'd0, 3'd1, 1'b0, 2'd0, 8'h00, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || req_rdy !== 1'b0 || count !== 9'd256 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_overflow: error=%b rdy=%b count=%0d done=%b expected 1,0,256,0", error, req_rdy, count, done);
    end
  endtask

  task automatic test_invalid();
    pulse_start();
    send(5'h1F, 3'd1, 3'd2, 3'd3, 3'd4, 1'b1, 2'd1, 8'h11, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || count !== 9'd0) begin
      failures++; $display("FAIL invalid_op: error=%b done=%b count=%0d expected 1,0,0", error, done, count);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || req_rdy !== 1'b1) begin
      failures++; $display("FAIL restart_clear: error=%b rdy=%b expected 0,1", error, req_rdy);
    end
    send(MN_MOVS, 3'd5, 3'd0, 3'd0, 3'd6, 1'b0, 2'd0, 8'h00, 1'b1, 1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 9'd1) begin
      failures++; $display("FAIL restart_done: done=%b count=%0d expected 1,1", done, count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    req_vld = 1; req_op = MN_ADD; req_dst = 3'd7; req_src0 = 3'd7; req_src1 = 3'd7; req_wren = 1;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    req_vld = 0;
    rst_n = 1;
    checks++;
    if ({req_rdy, prog_wr_en, prog_wr_addr, prog_wr_data, busy, done, error, count} !== '0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b en=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%0d, all zero expected",
               req_rdy, prog_wr_en, prog_wr_addr, prog_wr_data, busy, done, error, count);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    pulse_start();
    for (int i = 0; i < 40; i++)
      send(5'($urandom_range(0, 16)), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), 2'($urandom), 8'($urandom), (i == 39), 1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 9'd40 || error !== 1'b0) begin
      failures++; $display("FAIL random_done: done=%b count=%0d error=%b expected 1,40,0", done, count, error);
    end
  endtask

  initial begin
    exp_addr = 8'h00;
    test_reset();
    test_addi();
    test_jump_ret();
    test_not_ready();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL missing_writes: %0d outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
